// File: rtl/bc_bo_pkg.sv
// rtl/bc_bo_pkg.sv - shared mux select and ALU op encodings for the control unit and datapath
package bc_bo_pkg;

    localparam logic [1:0] SEL_A_X  = 2'd0;
    localparam logic [1:0] SEL_A_H  = 2'd1;
    localparam logic [1:0] SEL_A_S  = 2'd2;
    localparam logic [1:0] SEL_A_K0 = 2'd3;

    localparam logic [1:0] SEL_B_X  = 2'd0;
    localparam logic [1:0] SEL_B_K1 = 2'd1;
    localparam logic [1:0] SEL_B_H  = 2'd2;
    localparam logic [1:0] SEL_B_S  = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_ACC = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

endpackage

// File: rtl/bo_alu.sv
// rtl/bo_alu.sv - combinational shared ALU with per-op overflow detection
module bo_alu
    import bc_bo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        sum      = '0;
        prod     = '0;
        case (op_i)
            OP_ADD: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[WIDTH-1:0];
                ovf_o    = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                ovf_o    = (a_i < b_i);
            end
            OP_ACC: begin
                sum      = {1'b0, s_i} + {1'b0, a_i};
                result_o = sum[WIDTH-1:0];
                ovf_o    = sum[WIDTH];
            end
            default: begin
                prod     = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
                result_o = prod[WIDTH-1:0];
                ovf_o    = |prod[2*WIDTH-1:WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/bo_datapath.sv
// rtl/bo_datapath.sv - X/H/S register datapath driven by the sequencer control word
module bo_datapath
    import bc_bo_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] K0    = 1,
    parameter logic [WIDTH-1:0] K1    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LX,
    input  logic             LS,
    input  logic             LH,
    input  logic             H,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    input  logic [WIDTH-1:0] x_in,
    output logic [WIDTH-1:0] s_out,
    output logic             pronto,
    output logic             ovf
);

    logic [WIDTH-1:0] x_q, x_d, h_q, h_d, s_q, s_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d, pronto_q, pronto_d;
    logic [WIDTH-1:0] op_a, op_b, alu_res;
    logic             alu_ovf;

    always_comb begin
        case (M0)
            SEL_A_X: op_a = x_q;
            SEL_A_H: op_a = h_q;
            SEL_A_S: op_a = s_q;
            default: op_a = K0;
        endcase
        case (M1)
            SEL_B_X:  op_b = x_q;
            SEL_B_K1: op_b = K1;
            SEL_B_H:  op_b = h_q;
            default:  op_b = s_q;
        endcase
    end

    bo_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .s_i      (s_q),
        .op_i     (M2),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    // LS and LH may fire together; both consume the same pre-edge ALU result.
    always_comb begin
        x_d      = x_q;
        h_d      = h_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        pronto_d = 1'b0;
        if (LX) begin
            x_d   = x_in;
            h_d   = '0;
            s_d   = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (LH) h_d = H ? alu_res : x_in;
            if (LS) begin
                s_d      = alu_res;
                cnt_d    = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
                pronto_d = (cnt_q == 2'd2);
            end
            if ((LS || (LH && H)) && alu_ovf) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            h_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            h_q      <= h_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            pronto_q <= pronto_d;
        end
    end

    assign s_out  = s_q;
    assign pronto = pronto_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bo_datapath.sv
// tb/tb_bo_datapath.sv - directed self-checking bench for bo_datapath
module tb_bo_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       LX, LS, LH, H;
    logic [1:0] M0, M1, M2;
    logic [7:0] x_in;
    logic [7:0] s_out;
    logic       pronto, ovf;

    int total = 0;
    int bad   = 0;

    bo_datapath #(.WIDTH(8), .K0(8'd1), .K1(8'd2)) dut (
        .clk    (clk),
        .reset  (reset),
        .LX     (LX),
        .LS     (LS),
        .LH     (LH),
        .H      (H),
        .M0     (M0),
        .M1     (M1),
        .M2     (M2),
        .x_in   (x_in),
        .s_out  (s_out),
        .pronto (pronto),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one control word, clock it in, then sample 1 time unit after the edge.
    task automatic step(input logic lx, input logic ls, input logic lh, input logic h,
                        input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                        input logic [7:0] x);
        LX = lx; LS = ls; LH = lh; H = h; M0 = m0; M1 = m1; M2 = m2; x_in = x;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0);
    endtask

    task automatic word_a(input logic [7:0] x, input logic ls_too);
        step(1, ls_too, 0, 0, 2'd0, 2'd0, ls_too ? 2'd3 : 2'd0, x);
    endtask

    task automatic word_b(); step(0, 0, 1, 1, 2'd0, 2'd1, 2'd0, 8'd0); endtask
    task automatic word_c(); step(0, 1, 0, 0, 2'd0, 2'd2, 2'd3, 8'd0); endtask
    task automatic word_d(); step(0, 0, 1, 1, 2'd2, 2'd0, 2'd0, 8'd0); endtask
    task automatic word_e(); step(0, 1, 0, 0, 2'd0, 2'd2, 2'd3, 8'd0); endtask
    task automatic word_f(); step(0, 1, 0, 0, 2'd3, 2'd0, 2'd2, 8'd0); endtask

    task automatic run_seq(input string nm, input logic [7:0] x, input logic ls_with_lx,
                           input logic [7:0] sc, input logic [7:0] se, input logic [7:0] sf,
                           input logic ovf_c, input logic ovf_f);
        word_a(x, ls_with_lx);
        check({nm, ".A.s"}, s_out, 0);
        check({nm, ".A.ovf"}, ovf, 0);
        check({nm, ".A.pronto"}, pronto, 0);
        word_b();
        check({nm, ".B.s"}, s_out, 0);
        check({nm, ".B.pronto"}, pronto, 0);
        word_c();
        check({nm, ".C.s"}, s_out, sc);
        check({nm, ".C.ovf"}, ovf, ovf_c);
        check({nm, ".C.pronto"}, pronto, 0);
        word_d();
        check({nm, ".D.s"}, s_out, sc);
        check({nm, ".D.pronto"}, pronto, 0);
        word_e();
        check({nm, ".E.s"}, s_out, se);
        check({nm, ".E.pronto"}, pronto, 0);
        word_f();
        check({nm, ".F.s"}, s_out, sf);
        check({nm, ".F.ovf"}, ovf, ovf_f);
        check({nm, ".F.pronto"}, pronto, 1);
        idle();
        check({nm, ".idle.pronto"}, pronto, 0);
        check({nm, ".idle.s"}, s_out, sf);
    endtask

    initial begin
        reset = 1'b1;
        LX = 0; LS = 0; LH = 0; H = 0; M0 = 0; M1 = 0; M2 = 0; x_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.s", s_out, 0);
        check("rst.pronto", pronto, 0);
        check("rst.ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b0;

        // x=3: x*(x*(x+2)+x)+1
        run_seq("nom", 8'd3, 1'b0, 8'd15, 8'd54, 8'd55, 1'b0, 1'b0);

        // LH with H=0 loads x_in even while the ALU would overflow (S*S); ovf must hold 0
        step(0, 0, 1, 0, 2'd2, 2'd3, 2'd3, 8'd9);
        check("lh_x.ovf", ovf, 0);
        check("lh_x.s", s_out, 55);
        // 4th LS write: S = S + H = 55 + 9; no second pronto
        step(0, 1, 0, 0, 2'd1, 2'd0, 2'd2, 8'd0);
        check("ls4.s", s_out, 64);
        check("ls4.pronto", pronto, 0);
        check("ls4.ovf", ovf, 0);

        // x=20: 440 -> 184 (overflow), H=204, 4080 -> 240, 241
        run_seq("ovf", 8'd20, 1'b0, 8'd184, 8'd240, 8'd241, 1'b1, 1'b1);

        // Restart clears everything and reproduces 55
        run_seq("restart", 8'd3, 1'b0, 8'd15, 8'd54, 8'd55, 1'b0, 1'b0);

        // LX with LS and M2=MUL: LS ignored, count restarts so pronto lands on F again
        run_seq("prio", 8'd3, 1'b1, 8'd15, 8'd54, 8'd55, 1'b0, 1'b0);

        // Asynchronous reset mid-sequence after C of an overflowing run
        word_a(8'd20, 1'b0);
        word_b();
        word_c();
        check("mid.s_pre", s_out, 184);
        check("mid.ovf_pre", ovf, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid.s", s_out, 0);
        check("mid.ovf", ovf, 0);
        check("mid.pronto", pronto, 0);
        @(negedge clk);
        reset = 1'b0;
        run_seq("post_rst", 8'd3, 1'b0, 8'd15, 8'd54, 8'd55, 1'b0, 1'b0);

        // Simultaneous LS+LH: both take H+X = 5+3 from pre-edge values
        word_a(8'd3, 1'b0);
        word_b();
        word_c();
        step(0, 1, 1, 1, 2'd1, 2'd0, 2'd0, 8'd0);
        check("both.s", s_out, 8);
        check("both.ovf", ovf, 0);
        // S + H exposes H: 8 + 8 = 16 (stale H=5 would give 13)
        step(0, 1, 0, 0, 2'd1, 2'd0, 2'd2, 8'd0);
        check("both.h", s_out, 16);
        check("both.pronto", pronto, 1);

        // Idle control word changes nothing
        idle();
        idle();
        check("idle.s", s_out, 16);
        check("idle.pronto", pronto, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- Operational block (datapath) that consumes the control word from the sequencing control unit: LX, LS, LH, H, M0, M1, M2.
- Holds three registers, X, H and S, feeding one shared ALU. Evaluates the fixed polynomial sequence driven by the control unit.
- Reports the final S value, a one-cycle completion pulse and a sticky overflow flag.
- Sits directly below the control unit. Control signals are sampled as-is each cycle; there is no handshake back.

Parameters:
- WIDTH, 8, width of x_in, X, H, S and the ALU datapath.
- K0, 1, constant selected by M0=3.
- K1, 2, constant selected by M1=1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- LX  input  1  load X from x_in; restarts the computation.
- LS  input  1  write ALU result into S.
- LH  input  1  write into H; the source is chosen by H.
- H  input  1  H-register source select: 1 = ALU result, 0 = x_in.
- M0  input  2  ALU operand A select.
- M1  input  2  ALU operand B select.
- M2  input  2  ALU operation select.
- x_in  input  WIDTH  input operand.
- s_out  output  WIDTH  current S register contents.
- pronto  output  1  one-cycle pulse: result complete.
- ovf  output  1  sticky overflow since the last LX.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): X=0, H=0, S=0, ls_count=0, pronto=0, ovf=0.
- Operand A mux, M0: 0=X, 1=H, 2=S, 3=K0.
- Operand B mux, M1: 0=X, 1=K1, 2=H, 3=S.
- ALU op, M2 (combinational; result truncated to WIDTH):
  - 0 = A+B
  - 1 = A-B
  - 2 = S+A (accumulate; B ignored)
  - 3 = A*B
- Overflow condition for the current cycle:
  - add / accumulate: carry-out.
  - subtract: borrow (A<B).
  - multiply: upper WIDTH bits of the 2*WIDTH product are nonzero.
- At each rising edge, control values present in that cycle apply.
- If LX=1:
  - X<=x_in; H<=0; S<=0; ls_count<=0; ovf<=0; pronto<=0.
  - LX has priority: LS and LH are ignored in that cycle.
- Else if LH=1: H<=ALU result when H=1, else H<=x_in.
- Else if LS=1: S<=ALU result.
- LS and LH together in one cycle: both writes occur.
  - Both use the same pre-edge ALU result.
  - S and H see old register values (no forwarding).
- ovf update:
  - ovf<=1 when the overflow condition holds and the ALU result is actually written (LS=1, or LH=1 with H=1).
  - Otherwise ovf holds.
- ls_count (2-bit) counts LS writes since the last LX and saturates at 3.
- pronto<=1 for exactly one cycle, on the edge performing the 3rd LS write. It is low on every other edge.
  - Further LS writes do not re-pulse until the next LX.
- Latency: every register update is visible on s_out/pronto/ovf one edge after control is presented. s_out is the S register directly.
- All-zero control word (idle state): no register changes; pronto=0.

Decomposition:
- Shared package bc_bo_pkg:
  - M0 select constants: SEL_A_X, SEL_A_H, SEL_A_S, SEL_A_K0.
  - M1 select constants: SEL_B_X, SEL_B_K1, SEL_B_H, SEL_B_S.
  - M2 op codes: OP_ADD, OP_SUB, OP_ACC, OP_MUL.
  - The control unit uses the same package.
- One sub-module, bo_alu: combinational A/B/S/op in; WIDTH result plus overflow out. Registers, muxes and ls_count/pronto logic stay in bo_datapath.

Test Plan:
- Nominal sequence, x_in=3, driven with the six control words A..F as issued by the control unit:
  - H=5 after B; S=15 after C; H=18 after D; S=54 after E; S=55 after F.
  - pronto high only the cycle after F; ovf=0.
- Overflow, same sequence with x_in=20:
  - S=184 after C, ovf=1 from then on.
  - Final s_out=241; pronto pulses once; ovf remains 1.
- Restart: after the x_in=20 run, LX with x_in=3 → H=0, S=0, ovf=0. Re-running the sequence reproduces 55 with one pronto pulse.
- Priority: LX=1 together with LS=1, M2=3 → X loads, S=0, ls_count=0.
  - LH=1 with H=0 → H<=x_in, ovf unchanged.
  - A 4th LS write after F updates S but pronto stays 0.
- Reset mid-operation: assert reset asynchronously between edges after step C → s_out=0, pronto=0, ovf=0 immediately.
  - After release, a full sequence yields 55.
- Simultaneous LS+LH: X=3, H=5, S=15; LS=1, LH=1, H=1, M0=1, M1=0, M2=0 → S=8 and H=8 on the same edge.
